one_addr_sched: RTL

//  Scheduler in front of the one-address datapath. Accepts N-bit request vectors over a

---
 rtl/one_addr_pkg.sv | 23 ++
 rtl/one_addr_sched_if.sv | 27 ++
 rtl/one_addr_vec_fifo.sv | 59 +++++
 rtl/one_addr_sched.sv | 104 ++++++++++
 4 files changed

// File: rtl/one_addr_pkg.sv
// Shared helpers for the one-address datapath: address-width derivation and
// the MSB-first priority encoder used to pick the next granted address.
package one_addr_pkg;

    localparam int MAX_N = 64;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the highest set bit among the low n bits; 0 when none are set.
    function automatic int msb_index(input logic [MAX_N-1:0] vec, input int n);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/one_addr_sched_if.sv
// Request-vector input channel and granted-address output channel of the scheduler.
interface one_addr_sched_if
    import one_addr_pkg::*;
#(
    parameter int N = 8
);
    localparam int AW = addr_width(N);

    logic [N-1:0]  data;
    logic          vld_i;
    logic          rdy_o;
    logic [AW-1:0] addr;
    logic          vld_o;
    logic          rdy_i;
    logic          last_o;

    modport slave (
        input  data, vld_i, rdy_i,
        output rdy_o, addr, vld_o, last_o
    );

    modport master (
        output data, vld_i, rdy_i,
        input  rdy_o, addr, vld_o, last_o
    );

endinterface

// File: rtl/one_addr_vec_fifo.sv
// W-wide, DEPTH-entry synchronous FIFO with a combinational head read so the
// scheduler can reload its working register in the same cycle as the pop.
module one_addr_vec_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [W-1:0]                 data_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_d    = push_i ? ptr_inc(wr_q) : wr_q;
        rd_d    = pop_i  ? ptr_inc(rd_q) : rd_q;
        count_d = count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem[wr_q] <= data_i;
        end
    end

    assign head_o  = mem[rd_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/one_addr_sched.sv
// Serialises buffered request vectors into MSB-first addresses of their set bits,
// one per cycle, with a bubble-free reload of the next vector.
module one_addr_sched
    import one_addr_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    one_addr_sched_if.slave  bus,
    output logic             busy_o
);
    localparam int AW = addr_width(N);
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]  pend_q, pend_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          vld_q, vld_d;
    logic          last_q, last_d;

    logic [N-1:0]  rest;
    logic [N-1:0]  next_vec;
    logic [N-1:0]  fifo_head;
    logic [AW-1:0] sel;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          fifo_push, fifo_pop;
    logic          adv, accept, need_load, bypass;

    one_addr_vec_fifo #(
        .W     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  (bus.data),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        sel       = AW'(msb_index(MAX_N'(pend_q), N));
        rest      = pend_q & ~(N'(1) << sel);
        adv       = !vld_q || bus.rdy_i;
        accept    = bus.vld_i && !fifo_full;
        need_load = adv && ((pend_q == '0) || (rest == '0));

        // Next vector: FIFO head first, else the incoming vector straight through.
        next_vec = '0;
        fifo_pop = 1'b0;
        bypass   = 1'b0;
        if (!fifo_empty) begin
            next_vec = fifo_head;
            fifo_pop = need_load;
        end else if (accept) begin
            next_vec = bus.data;
            bypass   = need_load;
        end
        fifo_push = accept && !bypass;

        pend_d = pend_q;
        addr_d = addr_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (adv) begin
            if (pend_q != '0) begin
                addr_d = sel;
                vld_d  = 1'b1;
                last_d = (rest == '0);
                pend_d = (rest != '0) ? rest : next_vec;
            end else begin
                vld_d  = 1'b0;
                last_d = 1'b0;
                pend_d = next_vec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            addr_q <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            addr_q <= addr_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign bus.rdy_o  = !fifo_full;
    assign bus.addr   = addr_q;
    assign bus.vld_o  = vld_q;
    assign bus.last_o = last_q;
    assign busy_o     = (fifo_count != '0) || (pend_q != '0) || vld_q;

endmodule
